// File: rtl/mem_read_control.sv
// mem_read_control
//   Streams a captured buffer out of the dual-port capture RAM once the
//   trigger-driven writer reports completion. Reads are issued sequentially
//   from address 0. A skid FIFO of depth RD_LAT+1 absorbs the fixed RAM read
//   latency, so a stalled consumer never loses or duplicates a word.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   nwrite          words written per trigger
//   ntrigger        number of triggers captured
//   wr_done         writer status, high when the capture is complete
//   start           single-cycle readout request
//   raddr, rena     RAM read address / read enable
//   rdata           RAM read data, valid RD_LAT cycles after rena
//   out_data        stream data (FIFO head)
//   out_valid       stream valid
//   out_ready       stream ready from the consumer
//   out_last        marks the final word, qualified by out_valid
//   busy            readout in progress
//   done            one-cycle pulse when the final word has been accepted
//   start_err       sticky: start seen while wr_done=0 or busy=1
module mem_read_control #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        nwrite,
  input  logic [7:0]        ntrigger,
  input  logic              wr_done,
  input  logic              start,
  output logic [ADDR_W-1:0] raddr,
  output logic              rena,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              start_err
);

  localparam int DEPTH = RD_LAT + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        total_q, total_d;
  logic [15:0]        issued_q, issued_d;
  logic [15:0]        acc_q, acc_d;
  logic [RD_LAT-1:0]  vld_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic               start_err_q;

  logic [15:0]        total_calc;
  logic               push, pop, rena_c, last_beat;
  logic [7:0]         occ;

  function automatic logic [7:0] inflight(input logic [RD_LAT-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < RD_LAT; i++) n = n + 8'(v[i]);
    return n;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign total_calc = 16'(nwrite) * 16'(ntrigger);

  // The delay line tail marks the cycle rdata carries an issued word.
  assign push      = vld_q[RD_LAT-1];
  assign out_valid = (fifo_cnt_q != '0);
  assign pop       = out_valid & out_ready;
  assign last_beat = (acc_q == total_q - 16'd1);
  assign out_last  = out_valid & last_beat;
  // Gating keeps the port at zero while the (unreset) storage is idle.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  // Words in flight plus words parked, net of the word leaving this cycle.
  // Issuing only while this is below DEPTH bounds the FIFO at DEPTH entries
  // yet still allows one read per cycle when the consumer never stalls.
  assign occ = inflight(vld_q) + 8'(fifo_cnt_q) - {7'd0, pop};

  assign rena      = rena_c;
  assign raddr     = ADDR_W'(issued_q);
  assign busy      = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done      = (state_q == S_FIN);
  assign start_err = start_err_q;

  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    issued_d = issued_q;
    acc_d    = acc_q;
    rena_c   = 1'b0;

    if (state_q == S_READ && issued_q != total_q && occ < 8'(DEPTH))
      rena_c = 1'b1;
    if (rena_c) issued_d = issued_q + 16'd1;
    if (pop)    acc_d    = acc_q + 16'd1;

    unique case (state_q)
      S_IDLE: begin
        if (start && wr_done) begin
          total_d  = total_calc;
          issued_d = '0;
          acc_d    = '0;
          state_d  = (total_calc == 16'd0) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        if (pop && last_beat)        state_d = S_FIN;
        else if (issued_q == total_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && last_beat) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      total_q     <= '0;
      issued_q    <= '0;
      acc_q       <= '0;
      vld_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      start_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      issued_q   <= issued_d;
      acc_q      <= acc_d;
      fifo_cnt_q <= fifo_cnt_d;
      vld_q[0]   <= rena_c;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (start && (!wr_done || busy)) start_err_q <= 1'b1;
    end
  end

  // FIFO storage: data only, pointers and count carry the reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rdata;
  end

endmodule
